// File: rtl/lovelace_bus_pkg.sv
// Shared widths, field codes, FSM encoding and write payload for the component register bus.
package lovelace_bus_pkg;

    localparam int unsigned ID_W    = 2;
    localparam int unsigned FIELD_W = 2;
    localparam int unsigned FLOAT_W = 64;
    localparam int unsigned EXTRA_W = 32;
    localparam int unsigned SRC_W   = 3;

    typedef enum logic [1:0] {
        FIELD_FLOAT1 = 2'd0,
        FIELD_FLOAT2 = 2'd1,
        FIELD_FLOAT3 = 2'd2,
        FIELD_EXTRA  = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_NOTIFY = 2'd2
    } state_e;

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [ID_W-1:0]    id;
        logic [FIELD_W-1:0] field;
        logic [FLOAT_W-1:0] data;
        logic [EXTRA_W-1:0] mask;
    } wr_req_t;

endpackage

// File: rtl/comp_write_arbiter_if.sv
// Requester, register-bank and trace-unit signals of the component write arbiter.
interface comp_write_arbiter_if
    import lovelace_bus_pkg::*;
#(
    parameter int unsigned N_REQ = 3
);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [ID_W*N_REQ-1:0]    req_id;
    logic [FIELD_W*N_REQ-1:0] req_field;
    logic [FLOAT_W*N_REQ-1:0] req_data;
    logic [EXTRA_W*N_REQ-1:0] req_mask;
    logic [N_REQ-1:0]         req_lock;

    logic                     wr_valid;
    logic [ID_W-1:0]          wr_id;
    logic [FIELD_W-1:0]       wr_field;
    logic [FLOAT_W-1:0]       wr_data;
    logic [EXTRA_W-1:0]       wr_mask;
    logic                     wr_ready;

    logic                     upd_valid;
    logic [SRC_W-1:0]         upd_src;
    logic [ID_W-1:0]          upd_id;
    logic [FIELD_W-1:0]       upd_field;
    logic                     upd_ready;

    logic                     busy;
    logic                     err_pulse;

    // Arbiter side
    modport master (
        input  req_valid, req_id, req_field, req_data, req_mask, req_lock,
        input  wr_ready, upd_ready,
        output req_ready,
        output wr_valid, wr_id, wr_field, wr_data, wr_mask,
        output upd_valid, upd_src, upd_id, upd_field,
        output busy, err_pulse
    );

    // Requesters, bank and trace unit side
    modport slave (
        output req_valid, req_id, req_field, req_data, req_mask, req_lock,
        output wr_ready, upd_ready,
        input  req_ready,
        input  wr_valid, wr_id, wr_field, wr_data, wr_mask,
        input  upd_valid, upd_src, upd_id, upd_field,
        input  busy, err_pulse
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: a locked last winner keeps the grant, otherwise the
// first requester after the last winner (wrapping, last winner itself lowest) wins.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0] cand;

    // Descending scan so the nearest successor of last is the final assignment
    always_comb begin
        cand  = '0;
        idx   = last;
        any   = |req;
        if (!(lock[last] && req[last])) begin
            for (int k = int'(N); k >= 1; k--) begin
                cand = {1'b0, last} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(N)) begin
                    cand = cand - (IDX_W+1)'(N);
                end
                if (req[cand[IDX_W-1:0]]) begin
                    idx = cand[IDX_W-1:0];
                end
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/comp_write_arbiter.sv
// Shares the component register bank write port among N_REQ requesters:
// round-robin capture, one write in flight, optional trace notification.
module comp_write_arbiter
    import lovelace_bus_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned NOTIFY_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    comp_write_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

    state_e           state_q, state_d;
    wr_req_t          hold_q, hold_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wr_valid_q, wr_valid_d;
    logic             upd_valid_q, upd_valid_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic [N_REQ-1:0] req_ready_c;
    wr_req_t          req_arr [N_REQ];

    // Per-requester payload view; mask only meaningful for the extra field
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        logic [FIELD_W-1:0] fld;
        assign fld = bus.req_field[FIELD_W*g +: FIELD_W];
        assign req_arr[g] = '{
            src:   SRC_W'(g),
            id:    bus.req_id[ID_W*g +: ID_W],
            field: fld,
            data:  bus.req_data[FLOAT_W*g +: FLOAT_W],
            mask:  (fld == FIELD_EXTRA) ? bus.req_mask[EXTRA_W*g +: EXTRA_W] : {EXTRA_W{1'b0}}
        };
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req_valid),
        .lock  (bus.req_lock),
        .last  (last_grant_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    // Next-state, capture, timeout and registered-output decode
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        err_pulse_d  = 1'b0;
        req_ready_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    req_ready_c = grant;
                    hold_d      = req_arr[win_idx];
                    timer_d     = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.wr_ready) begin
                    last_grant_d = IDX_W'(hold_q.src);
                    state_d      = (NOTIFY_EN != 0) ? ST_NOTIFY : ST_IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    last_grant_d = IDX_W'(hold_q.src);
                    err_pulse_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_NOTIFY: begin
                if (bus.upd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_valid_d  = (state_d == ST_ISSUE);
        upd_valid_d = (state_d == ST_NOTIFY);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            last_grant_q <= LAST_INIT;
            timer_q      <= '0;
            err_pulse_q  <= 1'b0;
            wr_valid_q   <= 1'b0;
            upd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            err_pulse_q  <= err_pulse_d;
            wr_valid_q   <= wr_valid_d;
            upd_valid_q  <= upd_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Capture strobe is combinational and forced low while reset is held
    assign bus.req_ready = rst ? '0 : req_ready_c;

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_id     = wr_valid_q ? hold_q.id    : '0;
    assign bus.wr_field  = wr_valid_q ? hold_q.field : '0;
    assign bus.wr_data   = wr_valid_q ? hold_q.data  : '0;
    assign bus.wr_mask   = wr_valid_q ? hold_q.mask  : '0;

    assign bus.upd_valid = upd_valid_q;
    assign bus.upd_src   = upd_valid_q ? hold_q.src   : '0;
    assign bus.upd_id    = upd_valid_q ? hold_q.id    : '0;
    assign bus.upd_field = upd_valid_q ? hold_q.field : '0;

    assign bus.busy      = busy_q;
    assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_comp_write_arbiter.sv
// Bench for comp_write_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_comp_write_arbiter;
    import lovelace_bus_pkg::*;

    localparam int NR = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comp_write_arbiter_if #(.N_REQ(NR)) bus ();

    comp_write_arbiter #(
        .N_REQ     (NR),
        .TIMEOUT   (TO),
        .NOTIFY_EN (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observation logs, filled from DUT outputs by the checker process
    int          grant_log[$];
    logic [31:0] mask_log[$];
    int          wr_cyc, err_cnt, upd_cnt;

    // Model of the arbiter at transaction level
    int          m_phase;   // 0 waiting for requests, 1 write offered, 2 notify offered
    int          m_wait;    // cycles the current write has been offered without acceptance
    int          m_last;
    int          m_src;
    logic [1:0]  m_id, m_field;
    logic [63:0] m_data;
    logic [31:0] m_mask;
    logic        m_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] v, input logic [2:0] lk, input int last);
        int c;
        if (lk[2'(last)] && v[2'(last)]) return last;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (v[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_last = NR - 1; m_src = 0;
        m_id = '0; m_field = '0; m_data = '0; m_mask = '0; m_err = 1'b0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    initial begin
        logic [2:0]   exp_rr;
        logic [100:0] exp_wr;
        logic [7:0]   exp_upd;
        int           w;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", 128'({bus.req_ready, bus.wr_valid, bus.upd_valid, bus.busy, bus.err_pulse}), 128'(0));
                model_reset();
            end else begin
                w      = pick(bus.req_valid, bus.req_lock, m_last);
                exp_rr = (m_phase == 0 && w >= 0) ? 3'(1 << w) : 3'b000;
                exp_wr = (m_phase == 1) ? {1'b1, m_id, m_field, m_data, m_mask} : '0;
                exp_upd = (m_phase == 2) ? {1'b1, 3'(m_src), m_id, m_field} : '0;
                chk("cyc_req_ready", 128'(bus.req_ready), 128'(exp_rr));
                chk("cyc_wr", 128'({bus.wr_valid, bus.wr_id, bus.wr_field, bus.wr_data, bus.wr_mask}), 128'(exp_wr));
                chk("cyc_upd", 128'({bus.upd_valid, bus.upd_src, bus.upd_id, bus.upd_field}), 128'(exp_upd));
                chk("cyc_busy", 128'(bus.busy), 128'(m_phase != 0));
                chk("cyc_err", 128'(bus.err_pulse), 128'(m_err));

                for (int i = 0; i < NR; i++)
                    if (bus.req_ready == 3'(1 << i)) grant_log.push_back(i);
                if (bus.wr_valid) wr_cyc++;
                if (bus.err_pulse) err_cnt++;
                if (bus.upd_valid) upd_cnt++;
                if (bus.wr_valid && bus.wr_ready) mask_log.push_back(bus.wr_mask);

                m_err = 1'b0;
                if (m_phase == 0) begin
                    if (w >= 0) begin
                        m_src   = w;
                        m_id    = 2'(bus.req_id >> (2 * w));
                        m_field = 2'(bus.req_field >> (2 * w));
                        m_data  = 64'(bus.req_data >> (64 * w));
                        m_mask  = (m_field == 2'(FIELD_EXTRA)) ? 32'(bus.req_mask >> (32 * w)) : 32'h0;
                        m_wait  = 0;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (bus.wr_ready) begin
                        m_last  = m_src;
                        m_phase = 2;
                    end else if (m_wait + 1 == TO) begin
                        m_last  = m_src;
                        m_err   = 1'b1;
                        m_phase = 0;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    if (bus.upd_ready) m_phase = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] id, input logic [1:0] fld,
                           input logic [63:0] d, input logic [31:0] m);
        bus.req_id    = (bus.req_id & ~(6'(3) << (2 * i))) | (6'(id) << (2 * i));
        bus.req_field = (bus.req_field & ~(6'(3) << (2 * i))) | (6'(fld) << (2 * i));
        bus.req_data  = (bus.req_data & ~(192'({64{1'b1}}) << (64 * i))) | (192'(d) << (64 * i));
        bus.req_mask  = (bus.req_mask & ~(96'(32'hFFFF_FFFF) << (32 * i))) | (96'(m) << (32 * i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_log.delete();
        mask_log.delete();
        wr_cyc = 0; err_cnt = 0; upd_cnt = 0;
    endtask

    task automatic wait_grants(input int n, input string name);
        int t = 0;
        while (grant_log.size() < n && t < 60) begin
            step();
            t++;
        end
        chk(name, 128'(grant_log.size() >= n), 128'(1));
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (bus.busy && t < 60) begin
            step();
            t++;
        end
        chk(name, 128'(bus.busy), 128'(0));
    endtask

    task automatic pulse_req(input logic [2:0] v);
        bus.req_valid = v;
        step();
        bus.req_valid = '0;
    endtask

    // Directed scenarios
    initial begin
        int exp2[6] = '{0, 1, 2, 0, 1, 2};
        int exp3[5] = '{1, 1, 1, 1, 2};

        bus.req_valid = '0; bus.req_lock = '0;
        bus.req_id = '0; bus.req_field = '0; bus.req_data = '0; bus.req_mask = '0;
        bus.wr_ready = 1'b0; bus.upd_ready = 1'b0;
        wr_cyc = 0; err_cnt = 0; upd_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({bus.wr_valid, bus.upd_valid, bus.busy, bus.err_pulse, bus.wr_id, bus.upd_src}), 128'(0));
        rst = 1'b0;
        step();

        // Single float write from requester 0, latency pinned cycle by cycle
        bus.wr_ready = 1'b1; bus.upd_ready = 1'b1;
        set_req(0, 2'd2, 2'd1, $realtobits(120.0), 32'hDEAD_BEEF);
        bus.req_valid = 3'b001;
        #1;
        chk("t1_req_ready_c0", 128'(bus.req_ready), 128'(3'b001));
        @(posedge clk); #1;
        bus.req_valid = '0;
        #1;
        chk("t1_wr_valid_c1", 128'({bus.wr_valid, bus.wr_id, bus.wr_field}), 128'({1'b1, 2'd2, 2'd1}));
        chk("t1_wr_data", 128'(bus.wr_data), 128'(64'h405E_0000_0000_0000));
        chk("t1_wr_mask_float", 128'(bus.wr_mask), 128'(0));
        @(posedge clk); #2;
        chk("t1_upd_c2", 128'({bus.upd_valid, bus.upd_src, bus.upd_id, bus.upd_field}), 128'({1'b1, 3'd0, 2'd2, 2'd1}));
        step();
        wait_idle("t1_idle");

        // Three requesters held valid: plain rotation
        do_reset();
        set_req(0, 2'd1, 2'd0, $realtobits(1.0), 32'h0);
        set_req(1, 2'd2, 2'd3, 64'h0000_0000_0000_1234, 32'h0000_FFFF);
        set_req(2, 2'd3, 2'd2, $realtobits(-2.5), 32'hFFFF_0000);
        bus.req_valid = 3'b111;
        wait_grants(6, "t2_grant_wait");
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) chk($sformatf("t2_order_%0d", i), 128'(grant_log[i]), 128'(exp2[i]));
        wait_idle("t2_idle");

        // Lock keeps requester 1 until released, then requester 2
        do_reset();
        bus.req_lock  = 3'b010;
        bus.req_valid = 3'b110;
        wait_grants(4, "t3_lock_wait");
        bus.req_lock = '0;
        wait_grants(5, "t3_unlock_wait");
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order_%0d", i), 128'(grant_log[i]), 128'(exp3[i]));
        wait_idle("t3_idle");

        // Bank never accepts: abort after 16 offered cycles, next requester follows
        do_reset();
        bus.wr_ready  = 1'b0;
        bus.req_valid = 3'b001;
        wait_grants(1, "t4_first_wait");
        bus.req_valid = 3'b011;
        wait_grants(2, "t4_second_wait");
        bus.req_valid = '0;
        bus.wr_ready  = 1'b1;
        chk("t4_wr_cycles", 128'(wr_cyc), 128'(16));
        chk("t4_err_once", 128'(err_cnt), 128'(1));
        chk("t4_no_upd", 128'(upd_cnt), 128'(0));
        chk("t4_next_src", 128'(grant_log[1]), 128'(1));
        wait_idle("t4_idle");

        // Extra-field mask passes through; float write clears it
        do_reset();
        set_req(0, 2'd0, 2'd3, 64'h0000_0000_D000_0000, 32'hF000_0000);
        pulse_req(3'b001);
        wait_idle("t5_extra_idle");
        set_req(0, 2'd1, 2'd0, $realtobits(1.5), 32'hFFFF_FFFF);
        pulse_req(3'b001);
        wait_idle("t5_float_idle");
        chk("t5_mask_count", 128'(mask_log.size()), 128'(2));
        chk("t5_extra_mask", 128'(mask_log[0]), 128'(32'hF000_0000));
        chk("t5_float_mask", 128'(mask_log[1]), 128'(0));

        // Reset while a notification is stalled
        do_reset();
        bus.upd_ready = 1'b0;
        set_req(1, 2'd1, 2'd1, $realtobits(3.0), 32'h0);
        pulse_req(3'b010);
        step();
        chk("t6_in_notify", 128'({bus.upd_valid, bus.upd_src}), 128'({1'b1, 3'd1}));
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_clear", 128'({bus.req_ready, bus.wr_valid, bus.upd_valid, bus.upd_src, bus.upd_id,
                                    bus.upd_field, bus.busy, bus.err_pulse, bus.wr_id, bus.wr_field}), 128'(0));
        step();
        rst = 1'b0;
        bus.upd_ready = 1'b1;
        grant_log.delete();
        bus.req_valid = 3'b111;
        #1;
        chk("t6_req0_first", 128'(bus.req_ready), 128'(3'b001));
        step();
        bus.req_valid = '0;
        wait_idle("t6_idle");

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
